// File: rtl/fill_master.sv
// fill_master -- Avalon-MM master that paints a filled rectangle into a
// frame buffer one pixel per write.
//
// A one-cycle start in IDLE captures the rectangle bounds and the colour.
// A request that is out of range or inverted goes straight to FIN with
// error set. A valid request enters FILL and issues one write per pixel
// in raster order (x first, then y). It then passes through FIN for a
// single done cycle and returns to IDLE.
//
// Build option:
//   FILL_MASTER_GRADIENT_EN  when defined, brightness = colour + (x - x0)
//                            modulo 256; otherwise brightness = colour.
//
// Parameters:
//   VGA_ADDR     Avalon word address used for every pixel write.
//
// Ports:
//   clk          sole clock, all state updates on the rising edge
//   reset_n      asynchronous active-low reset
//   start        one-cycle fill request, sampled in IDLE only
//   x0, x1       inclusive column bounds (0..159)
//   y0, y1       inclusive row bounds (0..119)
//   colour       pixel brightness
//   busy         high in FILL and FIN
//   done         one-cycle completion pulse (FIN)
//   error        valid with done, high when the request was rejected
//   address      Avalon-MM address (VGA_ADDR while write=1, else 0)
//   write        Avalon-MM write strobe
//   writedata    {1'b0, y[6:0], x[7:0], 8'h00, brightness[7:0]}
//   waitrequest  slave stall; a write is accepted when write=1 and waitrequest=0

module fill_master #(
    parameter logic [3:0] VGA_ADDR = 4'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  x0,
    input  logic [7:0]  x1,
    input  logic [6:0]  y0,
    input  logic [6:0]  y1,
    input  logic [7:0]  colour,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  address,
    output logic        write,
    output logic [31:0] writedata,
    input  logic        waitrequest
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [7:0] X_MAX = 8'd159;
    localparam logic [6:0] Y_MAX = 7'd119;

    logic [1:0] state_q,  state_d;
    logic [7:0] x0_q,     x0_d;
    logic [7:0] x1_q,     x1_d;
    logic [6:0] y0_q,     y0_d;
    logic [6:0] y1_q,     y1_d;
    logic [7:0] colour_q, colour_d;
    logic [7:0] x_q,      x_d;
    logic [6:0] y_q,      y_d;
    logic       error_q,  error_d;

    logic       req_bad;
    logic       accept;
    logic [7:0] brightness;

    // Validation uses the live inputs because it is evaluated on the same
    // edge that captures them. Together with the bounds check, this keeps
    // the x/y counters from ever stepping past 159/119.
    assign req_bad = (x0 > x1) || (y0 > y1) || (x1 > X_MAX) || (y1 > Y_MAX);

    // A pixel is consumed only on a cycle where the slave does not stall.
    assign accept  = (state_q == ST_FILL) && !waitrequest;

    // NOTE: every signal assigned in this block gets a default first, so
    // paths that do not assign it cannot infer a latch.
    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        x1_d     = x1_q;
        y0_d     = y0_q;
        y1_d     = y1_q;
        colour_d = colour_q;
        x_d      = x_q;
        y_d      = y_q;
        error_d  = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x0_d     = x0;
                    x1_d     = x1;
                    y0_d     = y0;
                    y1_d     = y1;
                    colour_d = colour;
                    x_d      = x0;
                    y_d      = y0;
                    if (req_bad) begin
                        error_d = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        error_d = 1'b0;
                        state_d = ST_FILL;
                    end
                end
            end

            ST_FILL: begin
                if (accept) begin
                    if (x_q == x1_q) begin
                        x_d = x0_q;
                        if (y_q == y1_q) begin
                            state_d = ST_FIN;
                        end else begin
                            y_d = y_q + 7'd1;
                        end
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                end
            end

            ST_FIN: begin
                error_d = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                error_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            colour_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            x1_q     <= x1_d;
            y0_q     <= y0_d;
            y1_q     <= y1_d;
            colour_q <= colour_d;
            x_q      <= x_d;
            y_q      <= y_d;
            error_q  <= error_d;
        end
    end

`ifdef FILL_MASTER_GRADIENT_EN
    // Horizontal ramp: brightness rises by one per column from x0 and
    // wraps modulo 256.
    logic [7:0] x_offset;
    assign x_offset   = x_q - x0_q;
    assign brightness = colour_q + x_offset;
`else
    assign brightness = colour_q;
`endif

    // All outputs decode directly from registered state. While reset_n is
    // low the state is forced to IDLE, so write and the bus drop
    // immediately, without waiting for a clock edge. While stalled, the
    // state does not move, which holds the bus stable.
    assign write     = (state_q == ST_FILL);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign error     = (state_q == ST_FIN) && error_q;
    assign address   = write ? VGA_ADDR : 4'h0;
    assign writedata = write ? {1'b0, y_q, x_q, 8'h00, brightness} : 32'h0;

endmodule

// File: tb/tb_fill_master.sv
module tb_fill_master;

    localparam logic [3:0] TB_ADDR = 4'hA;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  x0, x1;
    logic [6:0]  y0, y1;
    logic [7:0]  colour;
    logic        busy, done, error;
    logic [3:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;

    int checks   = 0;
    int failures = 0;

    fill_master #(.VGA_ADDR(TB_ADDR)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .x0          (x0),
        .x1          (x1),
        .y0          (y0),
        .y1          (y1),
        .colour      (colour),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .address     (address),
        .write       (write),
        .writedata   (writedata),
        .waitrequest (waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference pixel word computed straight from the rectangle description.
    function automatic logic [31:0] pixel_word(input int x, input int y,
                                               input int xs, input logic [7:0] col);
        logic [7:0] b;
`ifdef FILL_MASTER_GRADIENT_EN
        b = 8'((int'(col) + (x - xs)) % 256);
`else
        b = col;
`endif
        return {1'b0, 7'(y), 8'(x), 8'h00, b};
    endfunction

    // Random junk on the request inputs while the master is busy.
    task automatic scramble();
        start  = 1'($urandom);
        x0     = 8'($urandom);
        x1     = 8'($urandom);
        y0     = 7'($urandom);
        y1     = 7'($urandom);
        colour = 8'($urandom);
    endtask

    task automatic recover();
        reset_n = 1'b0;
        start   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one request end to end. It is entered and left on a falling
    // edge with the master in IDLE. stall < 0 chooses 0..2 random stall
    // cycles per pixel.
    task automatic run_fill(input logic [7:0] ax0, input logic [7:0] ax1,
                            input logic [6:0] ay0, input logic [6:0] ay1,
                            input logic [7:0] acol, input int stall,
                            input string name);
        logic [31:0] exp_q[$];
        bit          valid;
        bit          ok;
        int          n;
        ok    = 1'b1;
        valid = !((ax0 > ax1) || (ay0 > ay1) || (ax1 > 8'd159) || (ay1 > 7'd119));
        if (valid) begin
            for (int y = int'(ay0); y <= int'(ay1); y++)
                for (int x = int'(ax0); x <= int'(ax1); x++)
                    exp_q.push_back(pixel_word(x, y, int'(ax0), acol));
        end

        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_busy: busy=%b expected 0", name, busy);
        end
        start = 1'b1; x0 = ax0; x1 = ax1; y0 = ay0; y1 = ay1; colour = acol;
        waitrequest = 1'b0;
        @(negedge clk);
        scramble();

        for (int i = 0; i < exp_q.size() && ok; i++) begin
            n = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            for (int k = 0; k <= n; k++) begin
                waitrequest = (k < n);
                checks++;
                if (write !== 1'b1 || writedata !== exp_q[i] || address !== TB_ADDR) begin
                    failures++;
                    $display("FAIL %s pixel %0d cyc %0d: write=%b writedata=%h address=%h expected write=1 writedata=%h address=%h",
                             name, i, k, write, writedata, address, exp_q[i], TB_ADDR);
                    ok = 1'b0;
                    break;
                end
                @(negedge clk);
                scramble();
            end
        end

        if (!ok) begin
            recover();
            return;
        end

        // FIN cycle: one done pulse, no write; a start here must be ignored.
        waitrequest = 1'b0;
        checks++;
        if (write !== 1'b0 || done !== 1'b1 || error !== !valid || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s fin: write=%b done=%b error=%b busy=%b expected write=0 done=1 error=%b busy=1",
                     name, write, done, error, busy, !valid);
            recover();
            return;
        end
        start = 1'b1; x0 = 8'd1; x1 = 8'd2; y0 = 7'd1; y1 = 7'd2;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || write !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL %s after_fin: busy=%b done=%b write=%b error=%b expected all 0",
                     name, busy, done, write, error);
            recover();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; waitrequest = 1'b0;
        x0 = 8'd3; x1 = 8'd4; y0 = 7'd3; y1 = 7'd4; colour = 8'h55;
        #3;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || write !== 1'b0 ||
            address !== 4'h0 || writedata !== 32'h0) begin
            failures++;
            $display("FAIL reset_values: busy=%b done=%b error=%b write=%b address=%h writedata=%h expected all 0",
                     busy, done, error, write, address, writedata);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || write !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: busy=%b write=%b expected 0 0", busy, write);
        end
    endtask

    task automatic test_single_pixel();
        run_fill(8'd5, 8'd5, 7'd7, 7'd7, 8'hAA, 0, "single_pixel");
        run_fill(8'd159, 8'd159, 7'd119, 7'd119, 8'h3C, -1, "corner_pixel");
    endtask

    task automatic test_stalls();
        run_fill(8'd0, 8'd2, 7'd0, 7'd1, 8'h10, 2, "stalls");
    endtask

    task automatic test_reject();
        run_fill(8'd0,  8'd160, 7'd0,  7'd5,   8'h11, 0, "reject_x1");
        run_fill(8'd0,  8'd10,  7'd0,  7'd120, 8'h22, 0, "reject_y1");
        run_fill(8'd20, 8'd19,  7'd0,  7'd5,   8'h33, 0, "reject_x_order");
        run_fill(8'd0,  8'd5,   7'd9,  7'd8,   8'h44, 0, "reject_y_order");
        run_fill(8'd150, 8'd159, 7'd5, 7'd5,   8'h55, -1, "edge_row");
    endtask

    task automatic test_full_screen();
        run_fill(8'd0, 8'd159, 7'd0, 7'd119, 8'h7E, 0, "full_screen");
    endtask

    task automatic test_random();
        logic [7:0] rx0, rx1;
        logic [6:0] ry0, ry1;
        for (int t = 0; t < 25; t++) begin
            rx0 = 8'($urandom_range(0, 165));
            rx1 = 8'(rx0 + 8'($urandom_range(0, 9)));
            ry0 = 7'($urandom_range(0, 122));
            ry1 = 7'(ry0 + 7'($urandom_range(0, 5)));
            if ($urandom_range(0, 7) == 0) begin
                rx1 = rx0 - 8'd1;
            end
            run_fill(rx0, rx1, ry0, ry1, 8'($urandom), -1, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_fill(8'd40, 8'd42, 7'd10, 7'd10, 8'hC0, 0, "b2b_first");
        run_fill(8'd43, 8'd44, 7'd11, 7'd12, 8'hC1, -1, "b2b_second");
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] exp3;
        exp3 = pixel_word(22, 30, 20, 8'h90);
        start = 1'b1; x0 = 8'd20; x1 = 8'd29; y0 = 7'd30; y1 = 7'd39; colour = 8'h90;
        waitrequest = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (write !== 1'b1 || writedata !== exp3) begin
            failures++;
            $display("FAIL midfill_pixel3: write=%b writedata=%h expected 1 %h", write, writedata, exp3);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (write !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || address !== 4'h0 || writedata !== 32'h0) begin
            failures++;
            $display("FAIL midfill_async_drop: write=%b busy=%b done=%b address=%h writedata=%h expected all 0",
                     write, busy, done, address, writedata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (write !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midfill_no_resume cyc %0d: write=%b busy=%b expected 0 0", c, write, busy);
            end
        end
        run_fill(8'd20, 8'd21, 7'd30, 7'd31, 8'h91, -1, "after_midfill");
    endtask

`ifdef FILL_MASTER_GRADIENT_EN
    task automatic test_gradient();
        run_fill(8'd10, 8'd13, 7'd0, 7'd0, 8'hFE, 0, "gradient");
    endtask
`endif

    initial begin
        test_reset();
        test_single_pixel();
        test_stalls();
        test_reject();
        test_back_to_back();
        test_random();
        test_reset_mid_fill();
`ifdef FILL_MASTER_GRADIENT_EN
        test_gradient();
`endif
        test_full_screen();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fill_master.md
FILL_MASTER -- requirements
Module: fill_master

Interface
REQ-001 SHALL have parameter VGA_ADDR, default 4'h0, the Avalon word address written for every pixel.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle fill request, sampled in IDLE only.
REQ-005 SHALL have port x0, x1  input  8 each  inclusive rectangle column bounds.
REQ-006 SHALL have port y0, y1  input  7 each  inclusive rectangle row bounds.
REQ-007 SHALL have port colour  input  8  pixel brightness.
REQ-008 SHALL have port busy  output  1  high from acceptance of start until done.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port error  output  1  valid with done; high when the request was rejected.
REQ-011 SHALL have port address  output  4  Avalon-MM master address.
REQ-012 SHALL have port write  output  1  Avalon-MM master write strobe.
REQ-013 SHALL have port writedata  output  32  Avalon-MM master write data.
REQ-014 SHALL have port waitrequest  input  1  slave stall; the write is accepted on a cycle with write=1 and waitrequest=0.

Function
REQ-015 SHALL implement states IDLE, FILL and FIN.
REQ-016 SHALL latch x0, x1, y0, y1 and colour on the clock edge that samples start=1 in IDLE.
- Later input changes SHALL have no effect on the fill in progress.
REQ-017 SHALL reject a request when x0>x1, y0>y1, x1>159 or y1>119.
- Rejection: IDLE->FIN, no write issued, error=1 during FIN.
REQ-018 SHALL, for a valid request, go IDLE->FIN via FILL with error=0.
- write=1 SHALL appear on the cycle after start is sampled, carrying pixel (x0,y0).
REQ-019 SHALL drive writedata as follows:
- [30:24] = y; [23:16] = x; [7:0] = brightness.
- All other bits = 0.
- address = VGA_ADDR whenever write=1.
REQ-020 SHALL hold write, address and writedata stable while waitrequest=1.
REQ-021 SHALL advance to the next pixel only on an accepted write.
- Raster order: x increments first; at x==x1, x returns to x0 and y increments.
REQ-022 SHALL go FILL->FIN on acceptance of pixel (x1,y1).
- write SHALL be 0 the following cycle.
- Exactly (x1-x0+1)*(y1-y0+1) writes SHALL be issued.
REQ-023 SHALL keep write=1 continuously in FILL, with one pixel per cycle when waitrequest=0 (no idle bubbles).
REQ-024 SHALL assert done for exactly one cycle in FIN, then return to IDLE.
- busy SHALL be 1 in FILL and FIN, 0 in IDLE.
REQ-025 SHALL ignore start while busy=1.
- start sampled in IDLE on the cycle after FIN SHALL be accepted.
REQ-026 SHALL use 8-bit x and 7-bit y counters with no wrap past x1/y1.
- Bounds checking per REQ-017 SHALL guarantee no overflow.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force the following:
- state IDLE.
- busy=0, done=0, error=0, write=0.
- address=0, writedata=0.
- All latched coordinates and counters 0.
REQ-028 SHALL abandon any fill in progress when reset asserts mid-fill, with write dropping immediately and no resumption after release.
REQ-029 SHALL accept no start until the first clock edge after reset_n deasserts.

Configuration
REQ-030 SHALL, with FILL_MASTER_GRADIENT_EN defined, drive brightness = colour + (x - x0), truncated modulo 256.
REQ-031 SHALL, with FILL_MASTER_GRADIENT_EN undefined, drive brightness = colour for every pixel, and SHALL contain no gradient adder.

Verification
REQ-032 SHALL cover single pixel: start with (5,7)-(5,7), colour 8'hAA, waitrequest=0 -> one write of 32'h070500AA; done and error=0 exactly one cycle later.
REQ-033 SHALL cover stalls: start with (0,0)-(2,1), colour 8'h10, waitrequest high 2 cycles before each acceptance -> 6 writes in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); writedata stable across every stall.
REQ-034 SHALL cover full screen: start with (0,0)-(159,119), waitrequest=0 -> 19200 consecutive write cycles; last writedata 32'h779F00xx; done on the next cycle.
REQ-035 SHALL cover rejection: start with x1=160 -> no write; done=1 and error=1 for one cycle; busy high for exactly that cycle.
REQ-036 SHALL cover reset mid-fill: reset_n low during pixel 3 of a 10x10 fill -> write=0 without waiting for a clock edge; after release, no writes until a new start.
REQ-037 SHALL cover the gradient build: with FILL_MASTER_GRADIENT_EN, start with (10,0)-(13,0), colour 8'hFE -> brightness FE, FF, 00, 01.
